controle_fechadura: RTL and testbench

- Sequencer for the serial combination lock.
- Frames serial key entry with a bit-valid strobe and compares the 6-bit code against a stored password.
- Drives open/error LEDs, counts consecutive failures, and enforces a timed lockout.
- Lets an authenticated user reprogram the password; sits between the keypad bit interface and the lock actuator/LEDs.

---
 rtl/controle_fechadura.sv | 194 +++++++++++++++++++
 tb/tb_controle_fechadura.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_fechadura.sv
// Serial combination lock sequencer: frames keyed bits, checks them against the password,
// drives the LEDs, counts failures and enforces lockout. CONTROLE_FECHADURA_PROG_EN enables reprogramming.
module controle_fechadura #(
   parameter int                N_BITS       = 6,
   parameter logic [N_BITS-1:0] SENHA_PADRAO = 6'b101100,
   parameter int                MAX_ERROS    = 3,
   parameter int                T_ABERTO     = 4,
   parameter int                T_ERRO       = 2,
   parameter int                T_BLOQUEIO   = 16,
   parameter int                T_INATIVO    = 8
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           X,
   input  logic                           bit_valid,
   input  logic                           prog,
   output logic                           LedVerde,
   output logic                           LedVermelho,
   output logic                           LedBloqueio,
   output logic [$clog2(MAX_ERROS+1)-1:0] tentativas
);

   function automatic int maior(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int T_MAX = maior(maior(T_ABERTO, T_ERRO), maior(T_BLOQUEIO, T_INATIVO));
   localparam int TW    = $clog2(T_MAX + 1);
   localparam int CW    = $clog2(N_BITS);
   localparam int EW    = $clog2(MAX_ERROS + 1);

   localparam logic [TW-1:0] FIM_ABERTO    = TW'(T_ABERTO - 1);
   localparam logic [TW-1:0] FIM_ERRO      = TW'(T_ERRO - 1);
   localparam logic [TW-1:0] FIM_BLOQUEIO  = TW'(T_BLOQUEIO - 1);
   localparam logic [TW-1:0] FIM_INATIVO   = TW'(T_INATIVO - 1);
   localparam logic [CW-1:0] ULTIMO_BIT    = CW'(N_BITS - 1);
   localparam logic [EW-1:0] LIMITE_ERROS  = EW'(MAX_ERROS);

   function automatic logic [EW-1:0] incr_sat(input logic [EW-1:0] v);
      return (v == LIMITE_ERROS) ? v : v + EW'(1);
   endfunction

   typedef enum logic [2:0] {
      OCIOSO, RECEBENDO, VERIFICA, ABERTO, ERRO, BLOQUEADO
`ifdef CONTROLE_FECHADURA_PROG_EN
      , PROGRAMA
`endif
   } estado_t;

   estado_t           estado, estado_n;
   logic [TW-1:0]     timer, timer_n;
   logic [CW-1:0]     cont, cont_n;
   logic [N_BITS-1:0] desloc, desloc_n, desloc_bit;
   logic [EW-1:0]     tent, tent_n, tent_inc;
   logic [N_BITS-1:0] senha_ref;

`ifdef CONTROLE_FECHADURA_PROG_EN
   logic [N_BITS-1:0] senha, senha_n;
   assign senha_ref = senha;
`else
   logic unused_prog;
   assign unused_prog = prog;
   assign senha_ref   = SENHA_PADRAO;
`endif

   assign desloc_bit = {desloc[N_BITS-2:0], X};
   assign tent_inc   = incr_sat(tent);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         estado <= OCIOSO;
         timer  <= '0;
         cont   <= '0;
         desloc <= '0;
         tent   <= '0;
`ifdef CONTROLE_FECHADURA_PROG_EN
         senha  <= SENHA_PADRAO;
`endif
      end else begin
         estado <= estado_n;
         timer  <= timer_n;
         cont   <= cont_n;
         desloc <= desloc_n;
         tent   <= tent_n;
`ifdef CONTROLE_FECHADURA_PROG_EN
         senha  <= senha_n;
`endif
      end
   end

   // Every transition that changes state also zeroes the timer, so each state starts counting at 0.
   always_comb begin
      estado_n = estado;
      timer_n  = timer + TW'(1);
      cont_n   = cont;
      desloc_n = desloc;
      tent_n   = tent;
`ifdef CONTROLE_FECHADURA_PROG_EN
      senha_n  = senha;
`endif
      case (estado)
         OCIOSO: begin
            timer_n = '0;
            if (bit_valid) begin
               desloc_n = desloc_bit;
               cont_n   = CW'(1);
               estado_n = RECEBENDO;
            end
         end
         RECEBENDO: begin
            if (bit_valid) begin
               desloc_n = desloc_bit;
               timer_n  = '0;
               if (cont == ULTIMO_BIT) begin
                  cont_n   = '0;
                  estado_n = VERIFICA;
               end else begin
                  cont_n = cont + CW'(1);
               end
            end else if (timer == FIM_INATIVO) begin
               timer_n  = '0;
               cont_n   = '0;
               estado_n = OCIOSO;
            end
         end
         VERIFICA: begin
            timer_n = '0;
            if (desloc == senha_ref) begin
               tent_n   = '0;
               estado_n = ABERTO;
            end else begin
               tent_n   = tent_inc;
               estado_n = (tent_inc == LIMITE_ERROS) ? BLOQUEADO : ERRO;
            end
         end
         ABERTO: begin
`ifdef CONTROLE_FECHADURA_PROG_EN
            if (prog) begin
               timer_n  = '0;
               cont_n   = '0;
               estado_n = PROGRAMA;
            end else
`endif
            if (timer == FIM_ABERTO) begin
               timer_n  = '0;
               estado_n = OCIOSO;
            end
         end
         ERRO: begin
            if (timer == FIM_ERRO) begin
               timer_n  = '0;
               estado_n = OCIOSO;
            end
         end
         BLOQUEADO: begin
            if (timer == FIM_BLOQUEIO) begin
               timer_n  = '0;
               tent_n   = '0;
               estado_n = OCIOSO;
            end
         end
`ifdef CONTROLE_FECHADURA_PROG_EN
         PROGRAMA: begin
            if (bit_valid) begin
               desloc_n = desloc_bit;
               timer_n  = '0;
               if (cont == ULTIMO_BIT) begin
                  senha_n  = desloc_bit;
                  cont_n   = '0;
                  estado_n = OCIOSO;
               end else begin
                  cont_n = cont + CW'(1);
               end
            end else if (timer == FIM_INATIVO) begin
               timer_n  = '0;
               cont_n   = '0;
               estado_n = OCIOSO;
            end
         end
`endif
         default: begin
            timer_n  = '0;
            cont_n   = '0;
            estado_n = OCIOSO;
         end
      endcase
   end

   assign LedVerde    = (estado == ABERTO);
   assign LedVermelho = (estado == ERRO) || (estado == BLOQUEADO);
   assign LedBloqueio = (estado == BLOQUEADO);
   assign tentativas  = tent;

endmodule

// File: tb/tb_controle_fechadura.sv
// Scoreboard bench for controle_fechadura: a code-level model queues the expected LED episodes,
// and a monitor matches each episode seen on the LEDs (start cycle, pattern, length, failure count).
module tb_controle_fechadura;

   localparam int          N_BITS       = 6;
   localparam logic [5:0]  SENHA_PADRAO = 6'b101100;
   localparam int          MAX_ERROS    = 3;
   localparam int          T_ABERTO     = 4;
   localparam int          T_ERRO       = 2;
   localparam int          T_BLOQUEIO   = 16;
   localparam int          T_INATIVO    = 8;
`ifdef CONTROLE_FECHADURA_PROG_EN
   localparam bit PROG_EN = 1'b1;
`else
   localparam bit PROG_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset_n, X, bit_valid, prog;
   logic       LedVerde, LedVermelho, LedBloqueio;
   logic [1:0] tentativas;

   controle_fechadura #(
      .N_BITS(N_BITS), .SENHA_PADRAO(SENHA_PADRAO), .MAX_ERROS(MAX_ERROS),
      .T_ABERTO(T_ABERTO), .T_ERRO(T_ERRO), .T_BLOQUEIO(T_BLOQUEIO), .T_INATIVO(T_INATIVO)
   ) dut (
      .clock(clock), .reset_n(reset_n), .X(X), .bit_valid(bit_valid), .prog(prog),
      .LedVerde(LedVerde), .LedVermelho(LedVermelho), .LedBloqueio(LedBloqueio),
      .tentativas(tentativas)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int         start;
      logic [2:0] leds;
      int         dur;
      int         tent;
      int         tent_after;
   } ev_t;

   ev_t        exp_q[$];
   int         n_cmp = 0;
   int         n_err = 0;
   bit         flush = 1'b1;
   bit         in_ev = 1'b0;
   logic [5:0] pw    = SENHA_PADRAO;
   int         fails = 0;

   task automatic check(input string nome, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Sends nb bits of code MSB first; gap<0 means random idle gaps of 0..6 cycles.
   task automatic enviar(input logic [5:0] code, input int nb, input int gap, output int k);
      int g;
      for (int i = 0; i < nb; i++) begin
         g = (gap < 0) ? $urandom_range(0, 6) : gap;
         repeat (g) begin
            bit_valid = 1'b0; X = 1'($urandom); prog = 1'($urandom);
            tick();
         end
         bit_valid = 1'b1; X = code[N_BITS-1-i]; prog = 1'($urandom);
         tick();
      end
      k = cyc;
      bit_valid = 1'b0; prog = 1'b0;
   endtask

   // Covers the verify cycle and the held state up to its exit edge, with noise on the inputs.
   task automatic janela(input int dur, input logic [2:0] leds);
      for (int j = 1; j <= dur + 1; j++) begin
         if (leds == 3'b011 && j >= 2 && j <= 7) begin
            bit_valid = 1'b1; X = pw[N_BITS-1-(j-2)];
         end else begin
            bit_valid = 1'($urandom); X = 1'($urandom);
         end
         prog = (leds == 3'b100 && PROG_EN) ? 1'b0 : 1'($urandom);
         tick();
      end
      bit_valid = 1'b0; prog = 1'b0;
   endtask

   task automatic entrada(input logic [5:0] code, input int gap);
      int  k;
      ev_t e;
      enviar(code, N_BITS, gap, k);
      e.start = k + 1;
      if (code == pw) begin
         fails = 0;
         e.leds = 3'b100; e.dur = T_ABERTO; e.tent = 0; e.tent_after = 0;
      end else begin
         fails++;
         if (fails == MAX_ERROS) begin
            e.leds = 3'b011; e.dur = T_BLOQUEIO; e.tent = MAX_ERROS; e.tent_after = 0;
            fails = 0;
         end else begin
            e.leds = 3'b010; e.dur = T_ERRO; e.tent = fails; e.tent_after = fails;
         end
      end
      exp_q.push_back(e);
      janela(e.dur, e.leds);
   endtask

   task automatic parcial(input logic [5:0] code, input int nb);
      int k;
      enviar(code, nb, -1, k);
      repeat (T_INATIVO) begin
         bit_valid = 1'b0; X = 1'($urandom); prog = 1'($urandom);
         tick();
      end
      prog = 1'b0;
   endtask

   task automatic programar(input logic [5:0] novo, input bit completo);
      int  k, p;
      ev_t e;
      enviar(pw, N_BITS, -1, k);
      fails = 0;
      p = $urandom_range(1, T_ABERTO);
      e.start = k + 1; e.leds = 3'b100; e.dur = p; e.tent = 0; e.tent_after = 0;
      exp_q.push_back(e);
      for (int j = 1; j <= p + 1; j++) begin
         bit_valid = (j <= p) ? 1'($urandom) : 1'b0;
         X = 1'($urandom);
         prog = (j == p + 1);
         tick();
      end
      prog = 1'b0;
      if (completo) begin
         enviar(novo, N_BITS, -1, k);
         pw = novo;
      end else begin
         parcial(novo, $urandom_range(1, 5));
      end
   endtask

   // Monitor: matches each LED episode against the head of the expected queue.
   logic [2:0] leds_m;
   ev_t        cur;
   int         dur_m;
   initial begin
      forever begin
         @(negedge clock);
         leds_m = {LedVerde, LedVermelho, LedBloqueio};
         if (flush) begin
            in_ev = 1'b0;
         end else if (in_ev) begin
            if (leds_m == cur.leds) begin
               dur_m++;
            end else begin
               check("duracao", dur_m, cur.dur);
               check("tentativas_fim", 32'(tentativas), cur.tent_after);
               check("leds_fim", 32'(leds_m), 0);
               in_ev = 1'b0;
            end
         end else if (leds_m != 3'b000) begin
            if (exp_q.size() == 0) begin
               check("leds_inesperados", 32'(leds_m), 0);
            end else begin
               cur = exp_q.pop_front();
               check("inicio", cyc, cur.start);
               check("leds", 32'(leds_m), 32'(cur.leds));
               check("tentativas", 32'(tentativas), cur.tent);
               in_ev = 1'b1;
               dur_m = 1;
            end
         end
      end
   end

   initial begin
      logic [5:0] c;
      int         k;
      ev_t        e;
      reset_n = 1'b0; X = 1'b0; bit_valid = 1'b0; prog = 1'b0;
      tick();
      tick();
      check("reset_leds", 32'({LedVerde, LedVermelho, LedBloqueio}), 0);
      check("reset_tentativas", 32'(tentativas), 0);
      reset_n = 1'b1;
      flush = 1'b0;

      entrada(SENHA_PADRAO, 0);
      entrada(6'b101101, 0);
      entrada(SENHA_PADRAO, -1);
      entrada(6'b000000, -1);
      entrada(6'b111111, -1);
      entrada(6'b101101, -1);
      entrada(SENHA_PADRAO, -1);
`ifdef CONTROLE_FECHADURA_PROG_EN
      programar(6'b010011, 1'b1);
      entrada(6'b101100, -1);
      entrada(6'b010011, -1);
`endif
      entrada(pw ^ 6'b000001, -1);
      parcial(6'b101000, 3);
      check("tentativas_apos_inatividade", 32'(tentativas), fails);
      check("leds_apos_inatividade", 32'({LedVerde, LedVermelho, LedBloqueio}), 0);
      entrada(pw, 2);

      for (int t = 0; t < 120; t++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: entrada(pw, -1);
            4, 5, 6, 7: begin
               c = 6'($urandom);
               entrada(c, -1);
            end
            8: parcial(6'($urandom), $urandom_range(1, 5));
            default: begin
`ifdef CONTROLE_FECHADURA_PROG_EN
               programar(6'($urandom), 1'($urandom));
`else
               entrada(pw, -1);
`endif
            end
         endcase
         repeat ($urandom_range(0, 3)) tick();
      end

`ifdef CONTROLE_FECHADURA_PROG_EN
      programar(6'b110011, 1'b1);
`endif
      entrada(pw, -1);
      entrada(pw ^ 6'b100000, -1);
      entrada(pw ^ 6'b000110, -1);
      enviar(pw ^ 6'b010000, N_BITS, -1, k);
      e.start = k + 1; e.leds = 3'b011; e.dur = T_BLOQUEIO; e.tent = MAX_ERROS; e.tent_after = 0;
      exp_q.push_back(e);
      repeat (6) tick();
      flush = 1'b1;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("reset_bloqueio_leds", 32'({LedVerde, LedVermelho, LedBloqueio}), 0);
      check("reset_bloqueio_tentativas", 32'(tentativas), 0);
      tick();
      flush = 1'b0;
      pw = SENHA_PADRAO;
      fails = 0;
      entrada(SENHA_PADRAO, -1);
      entrada(6'b011111, 0);
      entrada(SENHA_PADRAO, 0);

      repeat (30) tick();
      check("eventos_pendentes", exp_q.size(), 0);
      check("evento_em_curso", 32'(in_ev), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
